sbp_pipeline_injector: RTL

SBP_PIPELINE_INJECTOR -- requirements
Module: sbp_pipeline_injector

---
 rtl/sbp_pipeline_injector_if.sv | 38 +++
 rtl/sbp_pipeline_injector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sbp_pipeline_injector_if.sv
// Request-side bundle for sbp_pipeline_injector.
//
// Carries the lookup channel (valid/address/ready) and the update channel
// (valid/prefix/length/stage/location/result/ready) between a requester and
// the injector.
//   master : requester side, drives the valids and payloads, observes readies
//   slave  : injector side, observes the valids and payloads, drives readies
interface sbp_pipeline_injector_if #(
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int RESULT_BITS   = 24
);
  logic                     lkp_valid_i;
  logic [31:0]              lkp_ip_addr_i;
  logic                     lkp_ready_o;

  logic                     upd_valid_i;
  logic [31:0]              upd_prefix_i;
  logic [5:0]               upd_prefix_len_i;
  logic [STAGE_ID_BITS-1:0] upd_stage_id_i;
  logic [LOCATION_BITS-1:0] upd_location_i;
  logic [RESULT_BITS-1:0]   upd_result_i;
  logic                     upd_ready_o;

  modport master (
    output lkp_valid_i, lkp_ip_addr_i,
    output upd_valid_i, upd_prefix_i, upd_prefix_len_i,
    output upd_stage_id_i, upd_location_i, upd_result_i,
    input  lkp_ready_o, upd_ready_o
  );

  modport slave (
    input  lkp_valid_i, lkp_ip_addr_i,
    input  upd_valid_i, upd_prefix_i, upd_prefix_len_i,
    input  upd_stage_id_i, upd_location_i, upd_result_i,
    output lkp_ready_o, upd_ready_o
  );
endinterface

// File: rtl/sbp_pipeline_injector.sv
// Head-of-pipeline injector for a stage-based trie lookup engine.
//
// Merges lookup requests and queued update (node write) requests into one
// beat per cycle that feeds stage 1. Updates wait in a small FIFO; they win
// arbitration over lookups except that a waiting lookup is forced in after
// MAX_UPD_BURST consecutive update beats.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   req          request bundle (slave modport): lookup and update channels
//   update_o     head beat is an update (1) or lookup/idle (0)
//   ip_addr_o    lookup address, or masked update prefix
//   bit_pos_o    0 for lookups, min(prefix length, 32) for updates
//   stage_id_o   ROOT_STAGE_ID for lookups, target stage for updates, 0 idle
//   location_o   target location for updates, else 0
//   result_o     result field for updates, else 0
//   lkp_count_o  lookup beats injected (wraps)
//   upd_count_o  update beats injected (wraps)
module sbp_pipeline_injector #(
  parameter int STAGE_ID_BITS  = 6,
  parameter int LOCATION_BITS  = 11,
  parameter int RESULT_BITS    = 24,
  parameter int ROOT_STAGE_ID  = 1,
  parameter int UPD_FIFO_DEPTH = 4,
  parameter int MAX_UPD_BURST  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  sbp_pipeline_injector_if.slave   req,
  output logic                     update_o,
  output logic [31:0]              ip_addr_o,
  output logic [5:0]               bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,
  output logic [15:0]              lkp_count_o,
  output logic [15:0]              upd_count_o
);

  localparam int PTR_W   = $clog2(UPD_FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(MAX_UPD_BURST + 1);

  localparam logic [OCC_W-1:0]         DEPTH_C     = OCC_W'(UPD_FIFO_DEPTH);
  localparam logic [BURST_W-1:0]       MAX_BURST_C = BURST_W'(MAX_UPD_BURST);
  localparam logic [STAGE_ID_BITS-1:0] ROOT_C      = STAGE_ID_BITS'(ROOT_STAGE_ID);

  typedef struct packed {
    logic [31:0]              prefix;
    logic [5:0]               len;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } upd_entry_t;

  // Keep only the top 'len' bits of the prefix; len >= 32 keeps all of it.
  function automatic logic [31:0] mask_prefix(input logic [31:0] prefix,
                                              input logic [5:0]  len);
    logic [31:0] keep;
    if (len == 6'd0)
      keep = '0;
    else if (len >= 6'd32)
      keep = '1;
    else
      keep = 32'hFFFF_FFFF << (6'd32 - len);
    return prefix & keep;
  endfunction

  function automatic logic [5:0] clamp_bit_pos(input logic [5:0] len);
    return (len >= 6'd32) ? 6'd32 : len;
  endfunction

  upd_entry_t               fifo_mem_q [UPD_FIFO_DEPTH];
  upd_entry_t               wr_entry;
  upd_entry_t               rd_entry;

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic                     upd_ready_q, upd_ready_d;
  logic [BURST_W-1:0]       burst_q, burst_d;

  logic                     update_q, update_d;
  logic [31:0]              ip_addr_q, ip_addr_d;
  logic [5:0]               bit_pos_q, bit_pos_d;
  logic [STAGE_ID_BITS-1:0] stage_id_q, stage_id_d;
  logic [LOCATION_BITS-1:0] location_q, location_d;
  logic [RESULT_BITS-1:0]   result_q, result_d;
  logic [15:0]              lkp_count_q, lkp_count_d;
  logic [15:0]              upd_count_q, upd_count_d;

  logic                     push;
  logic                     pop;
  logic                     force_lkp;
  logic                     lkp_win;

  assign wr_entry.prefix   = req.upd_prefix_i;
  assign wr_entry.len      = req.upd_prefix_len_i;
  assign wr_entry.stage_id = req.upd_stage_id_i;
  assign wr_entry.location = req.upd_location_i;
  assign wr_entry.result   = req.upd_result_i;
  assign rd_entry          = fifo_mem_q[rd_ptr_q];

  // Arbitration. The ready used for push is the registered one, so a pop in
  // this cycle never makes room for a push in the same cycle, and an entry
  // pushed now is only visible to pop after the edge (no bypass).
  always_comb begin
    push      = req.upd_valid_i && upd_ready_q;
    force_lkp = req.lkp_valid_i && (burst_q == MAX_BURST_C);
    pop       = (occ_q != '0) && !force_lkp;
    lkp_win   = req.lkp_valid_i && !pop && rst;
  end

  assign req.lkp_ready_o = lkp_win;
  assign req.upd_ready_o = upd_ready_q;

  // FIFO bookkeeping and burst tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    upd_ready_d = (occ_d < DEPTH_C);

    // Burst only counts update beats taken while a lookup is waiting.
    burst_d = '0;
    if (req.lkp_valid_i && pop)
      burst_d = (burst_q == MAX_BURST_C) ? burst_q : burst_q + 1'b1;
  end

  // Head beat for the next edge: update, lookup, or all-zero idle.
  always_comb begin
    update_d    = 1'b0;
    ip_addr_d   = '0;
    bit_pos_d   = '0;
    stage_id_d  = '0;
    location_d  = '0;
    result_d    = '0;
    lkp_count_d = lkp_count_q;
    upd_count_d = upd_count_q;
    if (pop) begin
      update_d    = 1'b1;
      ip_addr_d   = mask_prefix(rd_entry.prefix, rd_entry.len);
      bit_pos_d   = clamp_bit_pos(rd_entry.len);
      stage_id_d  = rd_entry.stage_id;
      location_d  = rd_entry.location;
      result_d    = rd_entry.result;
      upd_count_d = upd_count_q + 16'd1;
    end else if (lkp_win) begin
      ip_addr_d   = req.lkp_ip_addr_i;
      stage_id_d  = ROOT_C;
      lkp_count_d = lkp_count_q + 16'd1;
    end
  end

  // Entry storage has no reset: occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      upd_ready_q <= 1'b0;
      burst_q     <= '0;
      update_q    <= 1'b0;
      ip_addr_q   <= '0;
      bit_pos_q   <= '0;
      stage_id_q  <= '0;
      location_q  <= '0;
      result_q    <= '0;
      lkp_count_q <= '0;
      upd_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      upd_ready_q <= upd_ready_d;
      burst_q     <= burst_d;
      update_q    <= update_d;
      ip_addr_q   <= ip_addr_d;
      bit_pos_q   <= bit_pos_d;
      stage_id_q  <= stage_id_d;
      location_q  <= location_d;
      result_q    <= result_d;
      lkp_count_q <= lkp_count_d;
      upd_count_q <= upd_count_d;
    end
  end

  assign update_o    = update_q;
  assign ip_addr_o   = ip_addr_q;
  assign bit_pos_o   = bit_pos_q;
  assign stage_id_o  = stage_id_q;
  assign location_o  = location_q;
  assign result_o    = result_q;
  assign lkp_count_o = lkp_count_q;
  assign upd_count_o = upd_count_q;

endmodule
